// File: rtl/sram_port_pkg.sv
// Shared types and constants for the per-node SRAM client ports.
package sram_port_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam int NODE_MASTER = 0;
    localparam int NODE_SLAVE1 = 1;
    localparam int NODE_SLAVE2 = 2;
    localparam int NODE_SLAVE3 = 3;
    localparam int NODE_SLAVE4 = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_e;

endpackage

// File: rtl/sram_client_port.sv
// CPU valid/ready front end for one node of the shared SRAM arbiter: holds a
// level request until req_done, returns a one-cycle response, then idles GAP_CYC cycles.
module sram_client_port
    import sram_port_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_ah,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,
    output logic              cpu_rsp_err,
    output logic              read_req,
    output logic              write_req,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              req_done,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e            state_q;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [7:0]        tout_q;
    logic [3:0]        gap_q;

    always_ff @(posedge clk or posedge reset_ah) begin
        if (reset_ah) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            tout_q      <= '0;
            gap_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                        wr_q    <= cpu_req_we;
                        rd_q    <= ~cpu_req_we;
                        tout_q  <= '0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // done is checked first so a done on the timeout edge still completes normally
                    if (req_done) begin
                        if (rd_q) rdata_q <= sram_rdata;
                        rsp_valid_q <= 1'b1;
                        rd_q        <= 1'b0;
                        wr_q        <= 1'b0;
                        gap_q       <= 4'(GAP_CYC);
                        state_q     <= GAP;
                    end else if (tout_q == 8'(TIMEOUT_CYC - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rd_q        <= 1'b0;
                        wr_q        <= 1'b0;
                        gap_q       <= 4'(GAP_CYC);
                        state_q     <= GAP;
                    end else begin
                        tout_q <= tout_q + 8'd1;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - 4'd1;
                    if (gap_q <= 4'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_req_ready = (state_q == IDLE);
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_err   = rsp_err_q;
    assign cpu_rsp_rdata = rdata_q;
    assign read_req      = rd_q;
    assign write_req     = wr_q;
    assign addr_out      = addr_q;
    assign data_out      = wdata_q;

endmodule
